// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier that borrows the shared ALU while busy.
// Optional sticky overflow output is enabled by defining MULSEQ_OVF_EN.
module alu_mul_seq #(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_f,
   output logic        alu_fsel,
   output logic        alu_csel,
   output logic        alu_ucin,
   input  logic [15:0] alu_y,
   input  logic        alu_cout
`ifdef MULSEQ_OVF_EN
   ,
   output logic        ovf
`endif
);

   typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, DONE} state_t;

   localparam logic [4:0] FN_PASS_A = 5'b00000;
   localparam logic [4:0] FN_SHL    = 5'b00001;
   localparam logic [4:0] FN_ADD    = 5'b10010;

   state_t      state;
   logic [15:0] acc;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic [4:0]  bit_cnt;
   logic        finished;

   // With early exit, a drained multiplier means no further partial products can contribute.
   assign finished = (bit_cnt == 5'd16) || (EARLY_EXIT && (mplier == 16'd0));

   assign alu_csel = 1'b0;
   assign alu_ucin = 1'b0;

   always_comb begin
      alu_a    = 16'h0000;
      alu_b    = 16'h0000;
      alu_f    = FN_PASS_A;
      alu_fsel = 1'b0;
      case (state)
         ADD: begin
            alu_a    = acc;
            alu_b    = mcand;
            alu_f    = FN_ADD;
            alu_fsel = 1'b0;
         end
         SHL: begin
            alu_a    = mcand;
            alu_b    = 16'h0001;
            alu_f    = FN_SHL;
            alu_fsel = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 16'h0000;
         acc     <= 16'h0000;
         mcand   <= 16'h0000;
         mplier  <= 16'h0000;
         bit_cnt <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand   <= op_a;
                  mplier  <= op_b;
                  acc     <= 16'h0000;
                  bit_cnt <= 5'd0;
                  busy    <= 1'b1;
                  state   <= TEST;
               end
            end
            TEST: begin
               // result and done are loaded together so result is valid in the done cycle.
               if (finished) begin
                  result <= acc;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (mplier[0]) begin
                  state <= ADD;
               end else begin
                  state <= SHL;
               end
            end
            ADD: begin
               acc   <= alu_y;
               state <= SHL;
            end
            SHL: begin
               mcand   <= alu_y;
               mplier  <= mplier >> 1;
               bit_cnt <= bit_cnt + 5'd1;
               state   <= TEST;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULSEQ_OVF_EN
   // Overflow is a carry out of an accumulate or a multiplicand bit lost while bits remain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) ovf <= 1'b0;
            ADD:  if (alu_cout) ovf <= 1'b1;
            SHL:  if (mcand[15] && ((mplier >> 1) != 16'd0)) ovf <= 1'b1;
            default: ;
         endcase
      end
   end
`else
   logic unused_cout;
   assign unused_cout = alu_cout;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, directed plus random multiplies vs an arithmetic model.
// Define MULSEQ_OVF_EN to also check the overflow flag.
module tb_alu_mul_seq;

   logic        clock;
   logic        resetN;
   logic        start;
   logic [15:0] opA;
   logic [15:0] opB;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [15:0] aluA;
   logic [15:0] aluB;
   logic [4:0]  aluF;
   logic        aluFsel;
   logic        aluCsel;
   logic        aluUcin;
   logic [15:0] aluY;
   logic        aluCout;
`ifdef MULSEQ_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;
   int carryViolations = 0;
   logic recording = 1'b0;
   logic [33:0] opsSeen[$];

   alu_mul_seq #(.EARLY_EXIT(1'b1)) dut (
      .clock(clock),
      .reset_n(resetN),
      .start(start),
      .op_a(opA),
      .op_b(opB),
      .busy(busy),
      .done(done),
      .result(result),
      .alu_a(aluA),
      .alu_b(aluB),
      .alu_f(aluF),
      .alu_fsel(aluFsel),
      .alu_csel(aluCsel),
      .alu_ucin(aluUcin),
      .alu_y(aluY),
      .alu_cout(aluCout)
`ifdef MULSEQ_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural stand-in for the shared ALU: pass A, ADD with carry, shift left.
   always_comb begin
      aluY    = 16'h0000;
      aluCout = 1'b0;
      if (aluFsel) aluY = aluA << aluB[3:0];
      else if (aluF == 5'b10010) {aluCout, aluY} = {1'b0, aluA} + {1'b0, aluB};
      else if (aluF == 5'b00000) aluY = aluA;
   end

   // Log every ALU operation the sequencer issues; code 1 = ADD, 2 = SHL, 3 = anything unexpected.
   always @(negedge clock) begin
      if (recording) begin
         if (aluCsel !== 1'b0 || aluUcin !== 1'b0) carryViolations++;
         if (aluFsel === 1'b0 && aluF === 5'b10010) opsSeen.push_back({2'd1, aluA, aluB});
         else if (aluFsel === 1'b1 && aluF === 5'b00001) opsSeen.push_back({2'd2, aluA, aluB});
         else if (!(aluFsel === 1'b0 && aluF === 5'b00000)) opsSeen.push_back({2'd3, aluA, aluB});
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleDrive(input string tag);
      checkOutput(tag, {aluA, aluB, aluF, aluFsel, aluCsel, aluUcin}, 32'd0);
   endtask

   function automatic int expectedLatency(input logic [15:0] b);
      int msb = -1;
      int ones = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) begin
            msb = i;
            ones++;
         end
      end
      if (msb < 0) return 1;
      return 1 + 2 * (msb + 1) + ones;
   endfunction

   // One complete multiply: accept, wait for done, check result/latency/ALU trace, then one idle cycle.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic holdStart,
                                input logic [15:0] nextA, input logic [15:0] nextB,
                                input logic pulseMid, input string tag);
      logic [31:0] full;
      logic [31:0] lowBits;
      logic [31:0] partial;
      logic [33:0] expOps[$];
      int expLat;
      int cyc;
      int opsBase;
      int carryBase;
      int mism;
      full = 32'(a) * 32'(b);
      expLat = expectedLatency(b);
      for (int i = 0; i < 16; i++) begin
         if ((b >> i) == 16'd0) break;
         if (b[i]) begin
            lowBits = 32'(b) & ((32'd1 << i) - 32'd1);
            partial = 32'(a) * lowBits;
            expOps.push_back({2'd1, partial[15:0], 16'(a << i)});
         end
         expOps.push_back({2'd2, 16'(a << i), 16'h0001});
      end
      opsBase = opsSeen.size();
      carryBase = carryViolations;
      recording = 1'b1;
      opA = a;
      opB = b;
      start = 1'b1;
      @(posedge clock);
      #1;
      if (holdStart) begin
         opA = nextA;
         opB = nextB;
      end else begin
         opA = 16'($urandom);
         opB = 16'($urandom);
         start = 1'b0;
      end
      cyc = 1;
      checkOutput({tag, "_busy_after_accept"}, busy, 1);
      while (done !== 1'b1 && cyc < 80) begin
         if (pulseMid && !holdStart) start = (cyc == 2);
         @(posedge clock);
         #1;
         cyc++;
      end
      if (!holdStart) start = 1'b0;
      checkOutput({tag, "_done_seen"}, done, 1);
      checkOutput({tag, "_done_cycle"}, cyc, expLat + 1);
      checkOutput({tag, "_result"}, result, full[15:0]);
      checkOutput({tag, "_busy_in_done"}, busy, 1);
`ifdef MULSEQ_OVF_EN
      checkOutput({tag, "_ovf"}, ovf, |full[31:16]);
`endif
      @(posedge clock);
      #1;
      recording = 1'b0;
      checkOutput({tag, "_done_one_cycle"}, done, 0);
      checkOutput({tag, "_busy_cleared"}, busy, 0);
      checkOutput({tag, "_result_held"}, result, full[15:0]);
      checkIdleDrive({tag, "_idle_drive"});
      checkOutput({tag, "_op_count"}, opsSeen.size() - opsBase, expOps.size());
      mism = 0;
      for (int i = 0; i < expOps.size() && (opsBase + i) < opsSeen.size(); i++) begin
         if (opsSeen[opsBase + i] !== expOps[i]) mism++;
      end
      checkOutput({tag, "_op_sequence"}, mism, 0);
      checkOutput({tag, "_carry_ctrl"}, carryViolations - carryBase, 0);
      if (!holdStart) begin
         @(posedge clock);
         #1;
         checkOutput({tag, "_not_queued"}, busy, 0);
      end
   endtask

   initial begin
      int doneCount;
      logic [15:0] ra;
      logic [15:0] rb;
      resetN = 1'b0;
      start = 1'b0;
      opA = 16'h0000;
      opB = 16'h0000;
      repeat (3) @(posedge clock);
      #1;
      $display("[TB] checking reset state");
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_result", result, 0);
      checkIdleDrive("reset_alu_drive");
`ifdef MULSEQ_OVF_EN
      checkOutput("reset_ovf", ovf, 0);
`endif
      resetN = 1'b1;
      @(posedge clock);
      #1;

      applyStimulus(16'h0003, 16'h0005, 1'b0, 16'h0, 16'h0, 1'b0, "mul_3x5");

      $display("[TB] reset in the middle of a multiply");
      opA = 16'h0003;
      opB = 16'h0005;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", done, 0);
      checkOutput("midreset_result", result, 0);
      checkIdleDrive("midreset_alu_drive");
      repeat (2) @(posedge clock);
      #1;
      resetN = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) doneCount++;
      end
      checkOutput("midreset_no_done", doneCount, 0);
      checkOutput("midreset_still_idle", busy, 0);

      applyStimulus(16'h0003, 16'h0005, 1'b0, 16'h0, 16'h0, 1'b0, "after_reset_3x5");
      applyStimulus(16'h1234, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, "mul_by_zero");
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0, 1'b0, "worst_case");
      applyStimulus(16'h0100, 16'h0100, 1'b0, 16'h0, 16'h0, 1'b0, "shift_out");
      applyStimulus(16'h00FF, 16'h0101, 1'b0, 16'h0, 16'h0, 1'b1, "max_no_ovf_midpulse");

      $display("[TB] back-to-back with start held high");
      applyStimulus(16'h0007, 16'h0009, 1'b1, 16'h0002, 16'h0008, 1'b0, "b2b_first");
      applyStimulus(16'h0002, 16'h0008, 1'b0, 16'h0, 16'h0, 1'b0, "b2b_second");

      $display("[TB] random multiplies");
      for (int n = 0; n < 16; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = 16'($urandom);
            1: rb = 16'($urandom) & 16'h00FF;
            2: rb = 16'($urandom) | 16'h8000;
            default: rb = 16'($urandom) & 16'h000F;
         endcase
         applyStimulus(ra, rb, 1'b0, 16'h0, 16'h0, n[0], "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 unsigned multiplier sequencer. Produces the truncated low 16-bit product.
- Owns the shared 16-bit ALU's control and operand inputs while busy, and performs shift-and-add using the ALU's ADD and SHIFT_LEFT functions.
- Sits between the CPU control unit and the ALU. The control unit hands the ALU to this block for the duration of a multiply.

Parameters:
- EARLY_EXIT, 1: 1 = stop as soon as the remaining multiplier is zero; 0 = always process all 16 bits.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled in IDLE only.
- op_a  input  16  multiplicand; latched on start accept.
- op_b  input  16  multiplier; latched on start accept.
- busy  output  1  high from the accept edge until DONE exits.
- done  output  1  one-cycle pulse; result valid.
- result  output  16  low 16 bits of op_a*op_b; held until the next accept.
- alu_a  output  16  ALU a operand.
- alu_b  output  16  ALU b operand.
- alu_f  output  5  ALU function code.
- alu_fsel  output  1  0 = logic/arith unit, 1 = shifter.
- alu_csel  output  1  carry select; always 0 (ucin).
- alu_ucin  output  1  carry in; always 0.
- alu_y  input  16  ALU result (combinational, same cycle).
- alu_cout  input  1  ALU carry out.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE; busy=0, done=0, result=0.
  - Internal acc, mcand and mplier all cleared.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- ALU drive in IDLE and DONE: alu_a=0, alu_b=0, alu_f=00000 (pass A), alu_fsel=0, alu_csel=0, alu_ucin=0.
- States: IDLE, TEST, ADD, SHL, DONE. Transitions on the rising clock edge.
- IDLE:
  - If start=1: mcand<=op_a, mplier<=op_b, acc<=0, busy<=1, go to TEST.
  - Otherwise stay.
- TEST (no ALU use):
  - If mplier==0 (EARLY_EXIT=1), or all 16 bits are consumed: go to DONE.
  - Else if mplier[0]=1: go to ADD.
  - Else: go to SHL.
- ADD:
  - Drive alu_a=acc, alu_b=mcand, alu_f=10010, alu_fsel=0.
  - acc<=alu_y; go to SHL.
- SHL:
  - Drive alu_a=mcand, alu_b=0x0001, alu_f=00001, alu_fsel=1.
  - mcand<=alu_y; mplier<=mplier>>1 (internal logical shift, zero fill).
  - Increment 5-bit bit counter; go to TEST.
- DONE:
  - result<=acc, done=1 for exactly one cycle, busy=0 on exit.
  - Go to IDLE.
- Latency (EARLY_EXIT=1):
  - done is high in cycle L+1 after the accept edge, where L = 1 + Σ(2+b[i]) for i=0..msb(op_b).
  - op_b=0 gives L=1.
  - op_b=0xFFFF gives L=49 (worst case).
  - EARLY_EXIT=0 always iterates 16 bits.
- start while busy or in DONE is ignored and is not queued.
- A new start is accepted on the cycle after DONE (back-to-back throughput).
- Products wrap modulo 2^16. alu_cout is ignored unless the optional feature is enabled.
- op_a and op_b may change freely after the accept edge.

Optional Feature:
- Macro MULSEQ_OVF_EN.
- When defined, adds output port ovf (1 bit, reset 0). ovf is cleared on start accept and set (sticky for the operation) on either event:
  - alu_cout=1 in ADD;
  - in SHL, mcand[15]=1 while (mplier>>1)!=0.
- ovf is valid with done and held until the next accept.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-multiply (op_a=3, op_b=5, reset_n low in cycle 4) -> busy=0, done never pulses, result=0; next start works normally.
- op_a=3, op_b=5 -> done in cycle 10 after accept, result=0x000F; ALU sees ADD, SHL, SHL, ADD, SHL in that order.
- op_a=0x1234, op_b=0 -> done in cycle 2, result=0x0000; no ADD state entered.
- op_a=0xFFFF, op_b=0xFFFF -> done in cycle 50, result=0x0001; ovf=1 with MULSEQ_OVF_EN.
- op_a=0x0100, op_b=0x0100 -> result=0x0000; ovf=1 (shift-out). op_a=0x00FF, op_b=0x0101 -> result=0xFFFF, ovf=0.
- start held high across two back-to-back operations (7*9 then 2*8), with start pulsed during busy -> mid-op pulse ignored; results 0x003F then 0x0010; second accept on the cycle after the first done.
